dm_latency_ctrl: RTL
====================

Name: dm_latency_ctrl

Overview:
- Parametrised successor to the pipeline data memory.
- Word-organised RAM with configurable depth and read/write latency, a valid/ready request handshake, and internal sub-word load/store alignment, merge and extension.
- Detects misaligned accesses and clears itself sequentially after reset instead of zeroing the whole array in one cycle.
- Sits in the MEM stage; the pipeline stalls on req_ready=0 and waits for rsp_valid.

Parameters:
- ADDR_W, 12, word-address bits; depth = 2^ADDR_W words.
- LATENCY, 1, cycles from request accept to rsp_valid; legal range 1..4.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset via the CLEAR state; 0 = contents undefined after reset.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request this cycle.
- req_we, input, 1, 1 = store, 0 = load.
- req_addr, input, 32, byte address.
- req_size, input, 2, 0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_sign, input, 1, loads only: 1 = sign-extend, 0 = zero-extend.
- req_wdata, input, 32, store data, taken from the low bits.
- req_pc, input, 32, PC of the instruction, used only for tracing.
- rsp_valid, output, 1, one-cycle response pulse.
- rsp_rdata, output, 32, extended load data; 0 for stores and for errors.
- addr_err, output, 1, valid with rsp_valid; misaligned or illegal size.
- busy, output, 1, high while the block is in CLEAR.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - rsp_valid=0, rsp_rdata=0, addr_err=0.
  - CLEAR_ON_RESET=1: state CLEAR, busy=1.
  - CLEAR_ON_RESET=0: state IDLE, busy=0.
- States: CLEAR, IDLE, WAIT, RESP. req_ready = (state==IDLE).
- CLEAR:
  - A clear index starts at 0 and zeroes one word per cycle.
  - After index 2^ADDR_W-1 is written, the next state is IDLE.
  - Exactly 2^ADDR_W cycles with busy=1.
- Accept: on an edge where state==IDLE and req_valid=1.
  - LATENCY=1: next state RESP.
  - Otherwise: next state WAIT, counter loaded with LATENCY-1.
- WAIT: counter decrements each cycle; when it reaches 1, the next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Timing: with an accept at edge E, rsp_valid is high in the cycle after edge E+LATENCY-1. Maximum throughput is one request per LATENCY+1 cycles.
- Word index = req_addr[ADDR_W+1:2]. Higher address bits are ignored, so accesses wrap modulo the depth.
- Alignment error (addr_err=1, no array write, rsp_rdata=0): size 1 with addr[0]=1; size 2 with addr[1:0]!=0; size 3.
- Stores are committed to the array at the accept edge.
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Half: bits [15:0] or [31:16], selected by addr[1], ← wdata[15:0].
  - Other lanes are preserved.
- Loads:
  - The word is read at the accept edge and the lane/half/word and extension mode are registered.
  - rsp_rdata is computed from the registered word.
  - Byte: lane addr[1:0]. Half: addr[1]. Extension: req_sign.
- Only one request is outstanding at a time; a load never observes a later store.
- Reset mid-operation: the outstanding request is dropped, with no rsp_valid. A store already committed at its accept edge remains. Entry to CLEAR (or IDLE) restarts.
- Requests are ignored in CLEAR, WAIT and RESP; req_valid may stay high while req_ready=0.

Optional Feature:
- DM_TRACE_EN defined: on every committed store, print $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2],2'b00}, merged_word).
  - merged_word is the full 32-bit word after the lane merge.
  - No print for erroring stores or for CLEAR writes.
- DM_TRACE_EN undefined: no display statements are compiled; function is identical.

Test Plan:
- ADDR_W=4, CLEAR_ON_RESET=1: 1-cycle reset → busy=1 and req_ready=0 for 16 cycles, then req_ready=1. A word load from 0x3C → rdata=0x00000000.
- LATENCY=1: sw 0x12345678 @0x10, then lw @0x10 → rsp_valid 1 cycle after each accept, rdata=0x12345678, addr_err=0. Next accept no earlier than 2 cycles later.
- Word 0x00000000 @0x20, sb wdata=0x000000F0 @0x23 → word=0xF0000000.
  - lb @0x23 sign=1 → 0xFFFFFFF0.
  - lbu → 0x000000F0.
  - lh @0x22 sign=1 → 0xFFFFF000.
- sh @0x21 → addr_err=1, rdata=0, array unchanged. lw @0x22 → addr_err=1. req_size=3 → addr_err=1.
- LATENCY=3: accept at edge E → rsp_valid exactly in the cycle after E+2. req_ready=0 for the 3 cycles between; held req_valid is accepted again right after RESP.
- LATENCY=4: assert reset 2 cycles after accepting a load → no rsp_valid, busy=1, CLEAR reruns. A store accepted before reset with CLEAR_ON_RESET=0 reads back its value.

Source files
------------

// File: rtl/dm_latency_ctrl.sv
// Word-organised data memory with configurable latency, valid/ready requests and sub-word alignment.
// Define DM_TRACE_EN to print every committed store (full merged word) to the simulation log.
module dm_latency_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        addr_err,
    output logic        busy
);

    // state   | meaning
    // S_CLEAR | zeroing one word per cycle after reset
    // S_IDLE  | ready to accept a request
    // S_WAIT  | latency counter running
    // S_RESP  | one-cycle response
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_idx;
    logic [2:0]        cnt;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic [31:0]       word_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              load_q;
    logic              err_q;

    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              addr_bad;
    logic [31:0]       cur_word;
    logic [31:0]       merged;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_widx;
    logic [31:0]       mem_wdata;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_ext;
    logic              unused_ok;

    assign idx       = req_addr[ADDR_W+1:2];
    assign accept    = (state == S_IDLE) && req_valid;
    assign cur_word  = mem[idx];
    assign unused_ok = ^{req_pc, req_addr[31:ADDR_W+2]};

    always_comb begin
        addr_bad = 1'b0;
        case (req_size)
            2'd0:    addr_bad = 1'b0;
            2'd1:    addr_bad = req_addr[0];
            2'd2:    addr_bad = (req_addr[1:0] != 2'b00);
            default: addr_bad = 1'b1;
        endcase
    end

    always_comb begin
        merged = cur_word;
        case (req_size)
            2'd0:    merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
            2'd1:    merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
            default: merged = req_wdata;
        endcase
    end

    // A request arriving on a reset edge is never accepted, so its store is suppressed too.
    assign mem_we    = !reset && ((state == S_CLEAR) || (accept && req_we && !addr_bad));
    assign mem_widx  = (state == S_CLEAR) ? clr_idx : idx;
    assign mem_wdata = (state == S_CLEAR) ? 32'd0 : merged;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && accept && req_we && !addr_bad) begin
            $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET != 0) state <= S_CLEAR;
            else                     state <= S_IDLE;
            clr_idx <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == '1) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (req_valid) begin
                        word_q <= cur_word;
                        lane_q <= req_addr[1:0];
                        size_q <= req_size;
                        sign_q <= req_sign;
                        load_q <= !req_we;
                        err_q  <= addr_bad;
                        if (LATENCY == 1) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 3'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd1) state <= S_RESP;
                    else             cnt   <= cnt - 1'b1;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign byte_v = word_q[{lane_q, 3'b000} +: 8];
    assign half_v = word_q[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = word_q;
        case (size_q)
            2'd0:    load_ext = {{24{sign_q & byte_v[7]}}, byte_v};
            2'd1:    load_ext = {{16{sign_q & half_v[15]}}, half_v};
            default: load_ext = word_q;
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state == S_CLEAR);
    assign rsp_valid = (state == S_RESP);
    assign addr_err  = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && load_q && !err_q) ? load_ext : 32'd0;

endmodule
